bin2bcd_seq: RTL and testbench

- Sequential shift-add-3 (double-dabble) converter: unsigned binary value in, packed BCD digits out, plus a leading-zero blank mask.
- Sits directly upstream of the hex7seg decoders; each 4-bit digit of bcd_out drives one decoder nibble.
- The blank mask lets the top level force unused display digits dark (segments all 1) instead of showing 0.
- Start/done handshake, one conversion in flight.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_adj.sv | 10 +
 rtl/bin2bcd_seq.sv | 119 +++++++++++
 tb/tb_bin2bcd_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter and the display path around it.
// Holds the FSM encoding, a digit-count sizing helper and the dark-segment pattern.
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Active-low decoders: all segments high means the digit is dark.
  localparam logic [6:0] BLANK_SEG = 7'b1111111;

  // ceil(width * log10(2)) in fixed point; width*log10(2) is never an integer for width > 0.
  function automatic int digits_for(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
// The 4-bit sum wraps; only digits 5..9 matter in a valid accumulator.
module bcd_digit_adj (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with start/done handshake.
// Results (digits, leading-zero blank mask, overflow) update only on the final shift.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow,
  output logic                  dbg_state
);

  // Handshake: start is sampled only while idle (busy=0); done is a one-cycle
  // pulse in the cycle after the last shift, and start may be raised in that
  // same cycle to begin the next conversion immediately.

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  logic [0:0]        r_state;
  logic [WIDTH-1:0]  r_bin;
  logic [AW-1:0]     r_acc;
  logic              r_ovf;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [AW-1:0]     r_bcd;
  logic [DIGITS-1:0] r_blank;
  logic              r_overflow;

  logic [AW-1:0]     w_adj;
  logic [AW-1:0]     w_acc_next;
  logic [WIDTH-1:0]  w_bin_next;
  logic              w_ovf_next;
  logic [DIGITS-1:0] w_blank;
  logic              w_lead;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // The adjusted accumulator MSB is the bit that falls off the top on this shift.
  assign w_acc_next = {w_adj[AW-2:0], r_bin[WIDTH-1]};
  assign w_bin_next = r_bin << 1;
  assign w_ovf_next = r_ovf | w_adj[AW-1];

  always_comb begin
    w_blank = '0;
    w_lead  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_lead     = w_lead & (w_acc_next[4*i +: 4] == 4'd0);
      w_blank[i] = w_lead;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bin      <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_blank    <= BLANK_RST;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bin   <= bin_in;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= CW'(WIDTH);
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_acc <= w_acc_next;
          r_bin <= w_bin_next;
          r_ovf <= w_ovf_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_bcd      <= w_acc_next;
            r_blank    <= w_blank;
            r_overflow <= w_ovf_next;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign bcd_out   = r_bcd;
  assign blank     = r_blank;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a 5-digit and a 3-digit instance, each checked
// by a monitor that pops expected {overflow, blank, bcd} and done-cycle queues.
module tb_bin2bcd_seq;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0;
  logic [W-1:0] bin_in = '0;
  logic        busy, done, overflow, dbg_state;
  logic [19:0] bcd_out;
  logic [4:0]  blank;

  logic        start3 = 1'b0;
  logic [W-1:0] bin3 = '0;
  logic        busy3, done3, overflow3, dbg_state3;
  logic [11:0] bcd3;
  logic [2:0]  blank3;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_cyc = 0;
  int busy_cnt = 0;
  int busy_cnt3 = 0;
  logic prev_done = 1'b0;
  logic prev_done3 = 1'b0;

  logic [25:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [15:0] exp3_q[$];
  int          exp3_cyc_q[$];

  bin2bcd_seq #(.WIDTH(W), .DIGITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .blank(blank),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  bin2bcd_seq #(.WIDTH(W), .DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .bin_in(bin3),
    .busy(busy3), .done(done3), .bcd_out(bcd3), .blank(blank3),
    .overflow(overflow3), .dbg_state(dbg_state3)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drivers.
  task automatic conv5(input logic [W-1:0] v, input logic [25:0] exp);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    last_cyc = cyc + 1 + W;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(last_cyc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic conv3(input logic [W-1:0] v, input logic [15:0] exp);
    @(negedge clk);
    start3 = 1'b1;
    bin3   = v;
    exp3_q.push_back(exp);
    exp3_cyc_q.push_back(cyc + 1 + W);
    @(negedge clk);
    start3 = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || exp3_q.size() != 0); i++)
      @(negedge clk);
    chk("drain_timeout", 64'(exp_q.size() + exp3_q.size()), 64'd0);
    exp_q.delete(); exp_cyc_q.delete(); exp3_q.delete(); exp3_cyc_q.delete();
    repeat (3) @(negedge clk);
  endtask

  // Monitors.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0; busy_cnt3 = 0; prev_done = 1'b0; prev_done3 = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (busy3) busy_cnt3++;
      if (done && prev_done) chk("done5_pulse_width", 64'd2, 64'd1);
      if (done3 && prev_done3) chk("done3_pulse_width", 64'd2, 64'd1);
      if (done) begin
        if (exp_q.size() == 0) chk("done5_unexpected", 64'd1, 64'd0);
        else begin
          chk("result5", 64'({overflow, blank, bcd_out}), 64'(exp_q.pop_front()));
          chk("done5_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
          chk("busy5_cycles", 64'(busy_cnt), 64'(W));
        end
        busy_cnt = 0;
      end
      if (done3) begin
        if (exp3_q.size() == 0) chk("done3_unexpected", 64'd1, 64'd0);
        else begin
          chk("result3", 64'({overflow3, blank3, bcd3}), 64'(exp3_q.pop_front()));
          chk("done3_cycle", 64'(cyc), 64'(exp3_cyc_q.pop_front()));
          chk("busy3_cycles", 64'(busy_cnt3), 64'(W));
        end
        busy_cnt3 = 0;
      end
      prev_done  = done;
      prev_done3 = done3;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_bcd"}, 64'(bcd_out), 64'd0);
    chk({tag, "_blank"}, 64'(blank), 64'b11110);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
    chk({tag, "_blank3"}, 64'(blank3), 64'b110);
    chk({tag, "_bcd3"}, 64'(bcd3), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    conv5(16'd0,     {1'b0, 5'b11110, 20'h00000});
    wait_idle();
    conv5(16'd65535, {1'b0, 5'b00000, 20'h65535});
    wait_idle();

    // Start held high across done: second conversion accepted in the done cycle.
    conv5(16'd1234,  {1'b0, 5'b10000, 20'h01234});
    repeat (5) @(negedge clk);
    start  = 1'b1;
    bin_in = 16'd9;
    exp_q.push_back({1'b0, 5'b11110, 20'h00009});
    exp_cyc_q.push_back(last_cyc + W + 1);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Start pulses and bin_in changes mid-conversion are ignored.
    conv5(16'd4321,  {1'b0, 5'b10000, 20'h04321});
    repeat (2) @(negedge clk);
    start = 1'b1; bin_in = 16'd42;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);

    // Reset mid-conversion aborts without a done pulse.
    conv5(16'd500,   {1'b0, 5'b10000, 20'h00500});
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("abort");
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    conv5(16'd7,     {1'b0, 5'b11110, 20'h00007});
    wait_idle();

    // Three-digit instance: overflow reporting and modulo digits.
    conv3(16'd1000,  {1'b1, 3'b110, 12'h000});
    wait_idle();
    conv3(16'd999,   {1'b0, 3'b000, 12'h999});
    wait_idle();
    conv3(16'd65535, {1'b1, 3'b000, 12'h535});
    wait_idle();
    conv3(16'd5,     {1'b0, 3'b110, 12'h005});
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
